// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared raster timing constants for the VGA blocks.
// Default mode: 640x480@60 from a 25 MHz pixel clock (one pixel per clk).
// Provides per-axis visible/front/sync/back lengths, totals, coordinate width
// and sync polarities (0 = active-low).
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned COORD_W   = 10;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam bit HSYNC_POL = 1'b0;
    localparam bit VSYNC_POL = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a counter modulo VISIBLE+FRONT+SYNC+BACK plus the
// active/sync levels that belong to the counter's NEXT value, so the parent
// can register them and stay cycle-aligned with the count.
// Ports:
//   clk          in   pixel clock
//   reset        in   synchronous active-high; loads TOTAL-1
//   en           in   count enable (advance by one, wrapping at TOTAL-1)
//   count        out  current counter register
//   active_next  out  next count < VISIBLE (0 while reset)
//   sync_next    out  POL while next count is in the sync window, else !POL
//   wrap         out  counter is enabled and at TOTAL-1 (next value is 0)
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VISIBLE = 640,
    parameter int unsigned FRONT   = 16,
    parameter int unsigned SYNC    = 96,
    parameter int unsigned BACK    = 48,
    parameter bit          POL     = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic               active_next,
    output logic               sync_next,
    output logic               wrap
);

    localparam int unsigned TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam int unsigned SYNC_START = VISIBLE + FRONT;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC;
    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

    if (TOTAL > (1 << COORD_W) || VISIBLE == 0 || TOTAL <= VISIBLE) begin : g_bad_params
        $error("vga_axis_counter: illegal timing, TOTAL=%0d must be in (VISIBLE, 2**COORD_W]", TOTAL);
    end

    logic [COORD_W-1:0] count_q;
    logic [COORD_W-1:0] count_d;
    logic [31:0]        count_ext;

    always_comb begin
        wrap = en && (count_q == LAST);
        if (reset) begin
            count_d = LAST;
        end else if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + COORD_W'(1);
        end else begin
            count_d = count_q;
        end
        // Widen once so the window compares work against the 32-bit bounds
        // (SYNC_END may equal 2**COORD_W when BACK is 0).
        count_ext   = 32'(count_d);
        active_next = !reset && (count_ext < VISIBLE);
        sync_next   = (!reset && count_ext >= SYNC_START && count_ext < SYNC_END) ? POL : !POL;
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Raster timing generator feeding the VGA renderer and the sync pins.
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN adds an 8-bit frame counter.
// Ports:
//   clk          in   pixel clock, all logic on posedge
//   reset        in   synchronous, active-high
//   x_px         out  horizontal count 0..H_TOTAL-1 (valid in blanking)
//   y_px         out  vertical count 0..V_TOTAL-1 (valid in blanking)
//   activevideo  out  x_px<H_VISIBLE && y_px<V_VISIBLE
//   hsync        out  HSYNC_POL inside the horizontal sync window
//   vsync        out  VSYNC_POL inside the vertical sync window
//   line_start   out  high while x_px==0
//   frame_start  out  high while x_px==0 && y_px==0
//   frame_cnt    out  frames started since reset, mod 256 (macro only)
// Every output is a flop; the strobes/levels are loaded from the counters'
// next values so they line up with x_px/y_px with no skew.
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_pkg::V_BACK,
    parameter bit          HSYNC_POL = vga_pkg::HSYNC_POL,
    parameter bit          VSYNC_POL = vga_pkg::VSYNC_POL
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] x_px,
    output logic [COORD_W-1:0] y_px,
    output logic               activevideo,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_cnt
`endif
);

    logic               h_wrap, v_wrap;
    logic               h_active_next, v_active_next;
    logic               h_sync_next, v_sync_next;
    logic [COORD_W-1:0] h_count, v_count;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (HSYNC_POL)
    ) u_h_counter (
        .clk         (clk),
        .reset       (reset),
        .en          (1'b1),
        .count       (h_count),
        .active_next (h_active_next),
        .sync_next   (h_sync_next),
        .wrap        (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (VSYNC_POL)
    ) u_v_counter (
        .clk         (clk),
        .reset       (reset),
        .en          (h_wrap),
        .count       (v_count),
        .active_next (v_active_next),
        .sync_next   (v_sync_next),
        .wrap        (v_wrap)
    );

    assign x_px = h_count;
    assign y_px = v_count;

    logic activevideo_q, activevideo_d;
    logic hsync_q,       hsync_d;
    logic vsync_q,       vsync_d;
    logic line_start_q,  line_start_d;
    logic frame_start_q, frame_start_d;

    always_comb begin
        activevideo_d = h_active_next && v_active_next;
        hsync_d       = h_sync_next;
        vsync_d       = v_sync_next;
        // h is always enabled, so h_wrap means the next x is 0; with v_wrap
        // as well the next (x,y) is (0,0).
        line_start_d  = !reset && h_wrap;
        frame_start_d = !reset && h_wrap && v_wrap;
    end

    always_ff @(posedge clk) begin
        activevideo_q <= activevideo_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        line_start_q  <= line_start_d;
        frame_start_q <= frame_start_d;
    end

    assign activevideo = activevideo_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        if (reset) begin
            frame_cnt_d = '0;
        end else if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// DUT A: default 640x480@60 timing. DUT B: H 8/2/2/2, V 4/1/1/1, HSYNC_POL=1.
// Stimulus pushes the expected output set for every cycle into a per-DUT
// queue; the negedge monitor pops and compares, and also gathers line/frame
// statistics that are checked against hand-computed constants at the end.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    typedef struct {
        int x;
        int y;
        bit av;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        int fc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic       av_a, hs_a, vs_a, ls_a, fs_a;
    logic       av_b, hs_b, vs_b, ls_b, fs_b;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] fc_a, fc_b;
    localparam bit USE_FC = 1'b1;
`else
    localparam bit USE_FC = 1'b0;
`endif

    vga_sync_gen u_dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .x_px        (x_a),
        .y_px        (y_a),
        .activevideo (av_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_a)
`endif
    );

    vga_sync_gen #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (2),
        .H_BACK    (2),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (1),
        .V_BACK    (1),
        .HSYNC_POL (1'b1),
        .VSYNC_POL (1'b0)
    ) u_dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .x_px        (x_b),
        .y_px        (y_b),
        .activevideo (av_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_b)
`endif
    );

    // Reference raster model working directly on (x,y) and the window bounds.
    function automatic exp_t model_step(input bit rst, input int ht, input int vt,
                                        input int hv, input int vv, input int hss, input int hse,
                                        input int vss, input int vse, input bit hp, input bit vp,
                                        inout int mx, inout int my, inout int mfc);
        exp_t e;
        if (rst) begin
            mx = ht - 1;
            my = vt - 1;
            mfc = 0;
            e.av = 1'b0;
            e.ls = 1'b0;
            e.fs = 1'b0;
            e.hs = !hp;
            e.vs = !vp;
        end else begin
            mx = (mx + 1) % ht;
            if (mx == 0) my = (my + 1) % vt;
            e.av = (mx < hv) && (my < vv);
            e.hs = (mx >= hss && mx < hse) ? hp : !hp;
            e.vs = (my >= vss && my < vse) ? vp : !vp;
            e.ls = (mx == 0);
            e.fs = (mx == 0) && (my == 0);
            if (e.fs) mfc = (mfc + 1) % 256;
        end
        e.x = mx;
        e.y = my;
        e.fc = mfc;
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t e, input int x, input int y,
                       input bit av, input bit hs, input bit vs, input bit ls, input bit fs,
                       input int fc);
        checks++;
        if (x != e.x || y != e.y || av != e.av || hs != e.hs || vs != e.vs ||
            ls != e.ls || fs != e.fs || (USE_FC && fc != e.fc)) begin
            errors++;
            $display("FAIL %s @%0t: got x=%0d y=%0d av=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d, expected x=%0d y=%0d av=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                     tag, $time, x, y, av, hs, vs, ls, fs, fc,
                     e.x, e.y, e.av, e.hs, e.vs, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor statistics.
    int cyc = 0;
    int a_ls_n = 0, a_ls_t0 = -1, a_ls_t1 = -1;
    int a_hs_cnt = 0, a_hs_min = 9999, a_hs_max = -1, a_av_fall = -1;
    int b_fs_n = 0, b_fs_t0 = -1, b_fs_t1 = -1;
    int b_hs_min = 9999, b_hs_max = -1;
    int b_vs_cnt = 0, b_vs_min = 9999, b_vs_max = -1;
    int b_fc255 = -1, b_fc256 = -1;

    always @(negedge clk) begin
        exp_t e;
        int fa, fb;
        cyc++;
        fa = 0;
        fb = 0;
`ifdef VGA_SYNC_FRAME_CNT_EN
        fa = int'(fc_a);
        fb = int'(fc_b);
`endif
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            cmp("dut_a", e, int'(x_a), int'(y_a), av_a, hs_a, vs_a, ls_a, fs_a, fa);
            if (ls_a) begin
                a_ls_n++;
                if (a_ls_n == 1) a_ls_t0 = cyc;
                if (a_ls_n == 2) a_ls_t1 = cyc;
            end
            if (a_ls_n == 1) begin
                if (!hs_a) begin
                    a_hs_cnt++;
                    if (int'(x_a) < a_hs_min) a_hs_min = int'(x_a);
                    if (int'(x_a) > a_hs_max) a_hs_max = int'(x_a);
                end
                if (!av_a && a_av_fall < 0) a_av_fall = int'(x_a);
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            cmp("dut_b", e, int'(x_b), int'(y_b), av_b, hs_b, vs_b, ls_b, fs_b, fb);
            if (fs_b) begin
                b_fs_n++;
                if (b_fs_n == 1) b_fs_t0 = cyc;
                if (b_fs_n == 2) b_fs_t1 = cyc;
                if (b_fs_n == 255) b_fc255 = fb;
                if (b_fs_n == 256) b_fc256 = fb;
            end
            if (b_fs_n == 1) begin
                if (hs_b) begin
                    if (int'(x_b) < b_hs_min) b_hs_min = int'(x_b);
                    if (int'(x_b) > b_hs_max) b_hs_max = int'(x_b);
                end
                if (!vs_b) begin
                    b_vs_cnt++;
                    if (int'(y_b) < b_vs_min) b_vs_min = int'(y_b);
                    if (int'(y_b) > b_vs_max) b_vs_max = int'(y_b);
                end
            end
        end
    end

    int ma_x = 0, ma_y = 0, ma_fc = 0;
    int mb_x = 0, mb_y = 0, mb_fc = 0;

    task automatic cycle(input bit ra, input bit rb);
        rst_a = ra;
        rst_b = rb;
        @(posedge clk);
        #1;
        q_a.push_back(model_step(ra, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0, 1'b0,
                                 ma_x, ma_y, ma_fc));
        q_b.push_back(model_step(rb, 14, 7, 8, 4, 10, 12, 5, 6, 1'b1, 1'b0,
                                 mb_x, mb_y, mb_fc));
    endtask

    initial begin
        bit mid_reset_done;
        bit ra;
        mid_reset_done = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);

        for (int i = 0; i < 26000; i++) begin
            // One-cycle reset of DUT A while it shows x=300, y=2.
            ra = !mid_reset_done && ma_x == 300 && ma_y == 2;
            if (ra) mid_reset_done = 1'b1;
            cycle(ra, 1'b0);
        end

        @(negedge clk);
        #1;

        check_int("queue_a_drained", q_a.size(), 0);
        check_int("queue_b_drained", q_b.size(), 0);
        check_int("mid_reset_issued", int'(mid_reset_done), 1);
        check_int("a_hsync_low_cycles", a_hs_cnt, 96);
        check_int("a_hsync_first_x", a_hs_min, 656);
        check_int("a_hsync_last_x", a_hs_max, 751);
        check_int("a_active_fall_x", a_av_fall, 640);
        check_int("a_line_period", a_ls_t1 - a_ls_t0, 800);
        check_int("b_frame_period", b_fs_t1 - b_fs_t0, 98);
        check_int("b_hsync_first_x", b_hs_min, 10);
        check_int("b_hsync_last_x", b_hs_max, 11);
        check_int("b_vsync_low_cycles", b_vs_cnt, 14);
        check_int("b_vsync_first_y", b_vs_min, 5);
        check_int("b_vsync_last_y", b_vs_max, 5);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check_int("b_frame_cnt_255", b_fc255, 255);
        check_int("b_frame_cnt_wrap", b_fc256, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
